// File: rtl/inst_bus_if.sv
// Instruction-fetch bridge: turns the core's ROM-style fetch port into a
// single-beat Wishbone read, with pipeline-stall hold, flush abort and bus timeout.
module inst_bus_if #(
  parameter logic [31:0] NOP_INST       = 32'h00000000,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_ce_i,
  input  logic [31:0] cpu_addr_i,
  output logic [31:0] cpu_data_o,
  input  logic [5:0]  stall_i,
  input  logic        flush_i,
  output logic        stallreq_o,
  output logic        bus_err_o,
  output logic [31:0] wb_adr_o,
  input  logic [31:0] wb_dat_i,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [3:0]  wb_sel_o,
  input  logic        wb_ack_i
);

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_BUSY       = 2'd1,
    S_WAIT_STALL = 2'd2
  } state_t;

  localparam logic [7:0] LP_CNT_LAST = 8'(TIMEOUT_CYCLES - 32'd1);

  state_t      r_state;
  logic [31:0] r_adr;
  logic [31:0] r_rd_buf;
  logic        r_cyc;
  logic        r_stb;
  logic [3:0]  r_sel;
  logic [7:0]  r_cnt;
  logic        r_bus_err;

  logic        w_issue;
  logic        w_take_ack;
  logic        w_timeout;
  logic        w_stalled;

  // Per-cycle decode of the current bus situation
  always_comb begin
    w_issue    = (r_state == S_IDLE) && cpu_ce_i && !flush_i;
    w_take_ack = (r_state == S_BUSY) && wb_ack_i && !flush_i;
    w_timeout  = (r_state == S_BUSY) && !wb_ack_i && !flush_i && (r_cnt == LP_CNT_LAST);
    w_stalled  = (stall_i != 6'd0);
  end

  // Instruction returned to the core; reset forces the NOP regardless of state
  always_comb begin
    cpu_data_o = NOP_INST;
    if (rst) begin
      cpu_data_o = NOP_INST;
    end else if (w_take_ack) begin
      cpu_data_o = wb_dat_i;
    end else if (w_timeout) begin
      cpu_data_o = NOP_INST;
    end else if (r_state == S_WAIT_STALL) begin
      cpu_data_o = r_rd_buf;
    end else begin
      cpu_data_o = NOP_INST;
    end
  end

  // Stall request: asserted while a fetch is being issued or is still pending
  always_comb begin
    stallreq_o = 1'b0;
    if (rst) begin
      stallreq_o = 1'b0;
    end else if (w_issue) begin
      stallreq_o = 1'b1;
    end else if ((r_state == S_BUSY) && !wb_ack_i && !flush_i && !w_timeout) begin
      stallreq_o = 1'b1;
    end else begin
      stallreq_o = 1'b0;
    end
  end

  // Fetch FSM with registered bus outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_adr     <= 32'h00000000;
      r_cyc     <= 1'b0;
      r_stb     <= 1'b0;
      r_sel     <= 4'h0;
      r_rd_buf  <= NOP_INST;
      r_cnt     <= 8'd0;
      r_bus_err <= 1'b0;
    end else begin
      r_bus_err <= w_timeout;
      case (r_state)
        S_IDLE: begin
          if (w_issue) begin
            r_adr   <= cpu_addr_i;
            r_cyc   <= 1'b1;
            r_stb   <= 1'b1;
            r_sel   <= 4'hF;
            r_cnt   <= 8'd0;
            r_state <= S_BUSY;
          end
        end
        S_BUSY: begin
          // Flush beats ack; a timeout completes the cycle like an ack carrying a NOP
          if (flush_i) begin
            r_cyc   <= 1'b0;
            r_stb   <= 1'b0;
            r_sel   <= 4'h0;
            r_state <= S_IDLE;
          end else if (wb_ack_i || w_timeout) begin
            r_cyc    <= 1'b0;
            r_stb    <= 1'b0;
            r_sel    <= 4'h0;
            r_rd_buf <= wb_ack_i ? wb_dat_i : NOP_INST;
            r_state  <= w_stalled ? S_WAIT_STALL : S_IDLE;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_WAIT_STALL: begin
          if (flush_i || !w_stalled) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_cyc   <= 1'b0;
          r_stb   <= 1'b0;
          r_sel   <= 4'h0;
        end
      endcase
    end
  end

  assign wb_adr_o  = r_adr;
  assign wb_cyc_o  = r_cyc;
  assign wb_stb_o  = r_stb;
  assign wb_sel_o  = r_sel;
  assign wb_we_o   = 1'b0;
  assign bus_err_o = r_bus_err;

endmodule

// File: tb/tb_inst_bus_if.sv
// Self-checking bench for inst_bus_if: scenario tasks with a queue of expected
// instructions pushed at stimulus time and popped when the DUT presents data.
module tb_inst_bus_if;

  localparam logic [31:0] TB_NOP     = 32'h00000000;
  localparam int          TB_TIMEOUT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_ce_i;
  logic [31:0] cpu_addr_i;
  logic [31:0] cpu_data_o;
  logic [5:0]  stall_i;
  logic        flush_i;
  logic        stallreq_o;
  logic        bus_err_o;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_i;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_we_o;
  logic [3:0]  wb_sel_o;
  logic        wb_ack_i;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] sb_q[$];
  logic [31:0] exp_data;

  inst_bus_if #(
    .NOP_INST      (TB_NOP),
    .TIMEOUT_CYCLES(TB_TIMEOUT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_ce_i  (cpu_ce_i),
    .cpu_addr_i(cpu_addr_i),
    .cpu_data_o(cpu_data_o),
    .stall_i   (stall_i),
    .flush_i   (flush_i),
    .stallreq_o(stallreq_o),
    .bus_err_o (bus_err_o),
    .wb_adr_o  (wb_adr_o),
    .wb_dat_i  (wb_dat_i),
    .wb_cyc_o  (wb_cyc_o),
    .wb_stb_o  (wb_stb_o),
    .wb_we_o   (wb_we_o),
    .wb_sel_o  (wb_sel_o),
    .wb_ack_i  (wb_ack_i)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; cpu_ce_i = 1'b1; cpu_addr_i = 32'h00000044; flush_i = 1'b0;
    stall_i = 6'd0; wb_ack_i = 1'b0; wb_dat_i = 32'h0;
    step(); step();
    @(negedge clk);
    checks++; if (wb_cyc_o !== 1'b0) begin errors++; $display("FAIL rst_cyc: got %b expected 0", wb_cyc_o); end
    checks++; if (wb_stb_o !== 1'b0) begin errors++; $display("FAIL rst_stb: got %b expected 0", wb_stb_o); end
    checks++; if (wb_sel_o !== 4'h0) begin errors++; $display("FAIL rst_sel: got %h expected 0", wb_sel_o); end
    checks++; if (wb_adr_o !== 32'h0) begin errors++; $display("FAIL rst_adr: got %h expected 0", wb_adr_o); end
    checks++; if (bus_err_o !== 1'b0) begin errors++; $display("FAIL rst_err: got %b expected 0", bus_err_o); end
    checks++; if (wb_we_o !== 1'b0) begin errors++; $display("FAIL rst_we: got %b expected 0", wb_we_o); end
    checks++; if (stallreq_o !== 1'b0) begin errors++; $display("FAIL rst_stallreq: got %b expected 0", stallreq_o); end
    checks++; if (cpu_data_o !== TB_NOP) begin errors++; $display("FAIL rst_data: got %h expected %h", cpu_data_o, TB_NOP); end
    rst = 1'b0; cpu_ce_i = 1'b0;
    step();
  endtask

  task automatic test_zero_wait();
    cpu_ce_i = 1'b1; cpu_addr_i = 32'h00000004;
    @(negedge clk);
    checks++; if (stallreq_o !== 1'b1) begin errors++; $display("FAIL zw_issue_stallreq: got %b expected 1", stallreq_o); end
    checks++; if (wb_cyc_o !== 1'b0) begin errors++; $display("FAIL zw_issue_cyc: got %b expected 0", wb_cyc_o); end
    step();
    cpu_ce_i = 1'b0; wb_ack_i = 1'b1; wb_dat_i = 32'h34011100; sb_q.push_back(32'h34011100);
    @(negedge clk);
    checks++; if ({wb_cyc_o, wb_stb_o, wb_sel_o} !== 6'b11_1111) begin errors++; $display("FAIL zw_bus: got cyc=%b stb=%b sel=%h expected 1 1 f", wb_cyc_o, wb_stb_o, wb_sel_o); end
    checks++; if (wb_adr_o !== 32'h00000004) begin errors++; $display("FAIL zw_adr: got %h expected 00000004", wb_adr_o); end
    checks++; if (stallreq_o !== 1'b0) begin errors++; $display("FAIL zw_ack_stallreq: got %b expected 0", stallreq_o); end
    exp_data = sb_q.pop_front();
    checks++; if (cpu_data_o !== exp_data) begin errors++; $display("FAIL zw_data: got %h expected %h", cpu_data_o, exp_data); end
    step();
    wb_ack_i = 1'b0; wb_dat_i = 32'h0;
    @(negedge clk);
    checks++; if (wb_cyc_o !== 1'b0) begin errors++; $display("FAIL zw_cyc_drop: got %b expected 0", wb_cyc_o); end
    checks++; if (cpu_data_o !== TB_NOP) begin errors++; $display("FAIL zw_after_data: got %h expected %h", cpu_data_o, TB_NOP); end
    step();
  endtask

  task automatic test_wait_states();
    int n_stall;
    n_stall = 0;
    cpu_ce_i = 1'b1; cpu_addr_i = 32'h00000100;
    @(negedge clk);
    if (stallreq_o === 1'b1) n_stall++;
    step();
    cpu_ce_i = 1'b0; cpu_addr_i = 32'hFFFFFFF0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (stallreq_o === 1'b1) n_stall++;
      checks++; if (wb_adr_o !== 32'h00000100) begin errors++; $display("FAIL ws_adr_%0d: got %h expected 00000100", i, wb_adr_o); end
      checks++; if (wb_cyc_o !== 1'b1) begin errors++; $display("FAIL ws_cyc_%0d: got %b expected 1", i, wb_cyc_o); end
      step();
    end
    wb_ack_i = 1'b1; wb_dat_i = 32'h00221825; sb_q.push_back(32'h00221825);
    @(negedge clk);
    if (stallreq_o === 1'b1) n_stall++;
    exp_data = sb_q.pop_front();
    checks++; if (cpu_data_o !== exp_data) begin errors++; $display("FAIL ws_data: got %h expected %h", cpu_data_o, exp_data); end
    checks++; if (wb_adr_o !== 32'h00000100) begin errors++; $display("FAIL ws_adr_ack: got %h expected 00000100", wb_adr_o); end
    step();
    wb_ack_i = 1'b0; wb_dat_i = 32'h0;
    @(negedge clk);
    checks++; if (n_stall !== 4) begin errors++; $display("FAIL ws_stall_cycles: got %0d expected 4", n_stall); end
    checks++; if (bus_err_o !== 1'b0) begin errors++; $display("FAIL ws_no_err: got %b expected 0", bus_err_o); end
    checks++; if (wb_cyc_o !== 1'b0) begin errors++; $display("FAIL ws_cyc_drop: got %b expected 0", wb_cyc_o); end
    step();
  endtask

  task automatic test_stall_hold();
    cpu_ce_i = 1'b1; cpu_addr_i = 32'h00000008;
    step();
    cpu_ce_i = 1'b0; wb_ack_i = 1'b1; wb_dat_i = 32'h3C020404; stall_i = 6'b000111;
    sb_q.push_back(32'h3C020404);
    @(negedge clk);
    exp_data = sb_q.pop_front();
    checks++; if (cpu_data_o !== exp_data) begin errors++; $display("FAIL sh_ack_data: got %h expected %h", cpu_data_o, exp_data); end
    step();
    // A stray ack in WAIT_STALL must not disturb the held instruction
    wb_ack_i = 1'b1; wb_dat_i = 32'hDEADBEEF; sb_q.push_back(32'h3C020404);
    @(negedge clk);
    exp_data = sb_q.pop_front();
    checks++; if (cpu_data_o !== exp_data) begin errors++; $display("FAIL sh_wait1_data: got %h expected %h", cpu_data_o, exp_data); end
    checks++; if (stallreq_o !== 1'b0) begin errors++; $display("FAIL sh_wait1_stallreq: got %b expected 0", stallreq_o); end
    checks++; if (wb_cyc_o !== 1'b0) begin errors++; $display("FAIL sh_wait1_cyc: got %b expected 0", wb_cyc_o); end
    step();
    wb_ack_i = 1'b0; wb_dat_i = 32'h0; stall_i = 6'd0; sb_q.push_back(32'h3C020404);
    @(negedge clk);
    exp_data = sb_q.pop_front();
    checks++; if (cpu_data_o !== exp_data) begin errors++; $display("FAIL sh_wait2_data: got %h expected %h", cpu_data_o, exp_data); end
    step();
    @(negedge clk);
    checks++; if (cpu_data_o !== TB_NOP) begin errors++; $display("FAIL sh_idle_data: got %h expected %h", cpu_data_o, TB_NOP); end
    step();
  endtask

  task automatic test_flush_vs_ack();
    cpu_ce_i = 1'b1; cpu_addr_i = 32'h0000000C;
    step();
    cpu_ce_i = 1'b0; flush_i = 1'b1; wb_ack_i = 1'b1; wb_dat_i = 32'h12345678; stall_i = 6'b000001;
    @(negedge clk);
    checks++; if (cpu_data_o !== TB_NOP) begin errors++; $display("FAIL fa_data: got %h expected %h", cpu_data_o, TB_NOP); end
    checks++; if (stallreq_o !== 1'b0) begin errors++; $display("FAIL fa_stallreq: got %b expected 0", stallreq_o); end
    step();
    flush_i = 1'b0; wb_ack_i = 1'b0; wb_dat_i = 32'h0;
    @(negedge clk);
    checks++; if (wb_cyc_o !== 1'b0) begin errors++; $display("FAIL fa_cyc: got %b expected 0", wb_cyc_o); end
    checks++; if (cpu_data_o !== TB_NOP) begin errors++; $display("FAIL fa_no_capture: got %h expected %h", cpu_data_o, TB_NOP); end
    step();
    stall_i = 6'd0;
    // Flush in IDLE blocks the issue even with ce high
    cpu_ce_i = 1'b1; flush_i = 1'b1; cpu_addr_i = 32'h00000030;
    @(negedge clk);
    checks++; if (stallreq_o !== 1'b0) begin errors++; $display("FAIL idle_flush_stallreq: got %b expected 0", stallreq_o); end
    step();
    @(negedge clk);
    checks++; if (wb_cyc_o !== 1'b0) begin errors++; $display("FAIL idle_flush_cyc: got %b expected 0", wb_cyc_o); end
    cpu_ce_i = 1'b0; flush_i = 1'b0;
    step();
  endtask

  task automatic test_timeout();
    cpu_ce_i = 1'b1; cpu_addr_i = 32'h00000020;
    step();
    cpu_ce_i = 1'b0; wb_dat_i = 32'hFFFFFFFF;
    for (int i = 0; i < TB_TIMEOUT - 1; i++) begin
      @(negedge clk);
      checks++; if ({stallreq_o, wb_cyc_o, bus_err_o} !== 3'b110) begin errors++; $display("FAIL to_wait_%0d: got stallreq=%b cyc=%b err=%b expected 1 1 0", i, stallreq_o, wb_cyc_o, bus_err_o); end
      step();
    end
    @(negedge clk);
    checks++; if (stallreq_o !== 1'b0) begin errors++; $display("FAIL to_last_stallreq: got %b expected 0", stallreq_o); end
    checks++; if (cpu_data_o !== TB_NOP) begin errors++; $display("FAIL to_last_data: got %h expected %h", cpu_data_o, TB_NOP); end
    checks++; if (wb_cyc_o !== 1'b1) begin errors++; $display("FAIL to_last_cyc: got %b expected 1", wb_cyc_o); end
    step();
    @(negedge clk);
    checks++; if (wb_cyc_o !== 1'b0) begin errors++; $display("FAIL to_cyc_drop: got %b expected 0", wb_cyc_o); end
    checks++; if (bus_err_o !== 1'b1) begin errors++; $display("FAIL to_err_pulse: got %b expected 1", bus_err_o); end
    step();
    @(negedge clk);
    checks++; if (bus_err_o !== 1'b0) begin errors++; $display("FAIL to_err_one_cycle: got %b expected 0", bus_err_o); end
    wb_dat_i = 32'h0;
    step();
  endtask

  task automatic test_reset_busy();
    cpu_ce_i = 1'b1; cpu_addr_i = 32'h00000040;
    step();
    cpu_ce_i = 1'b0; rst = 1'b1;
    @(negedge clk);
    checks++; if (cpu_data_o !== TB_NOP) begin errors++; $display("FAIL rb_data_in_rst: got %h expected %h", cpu_data_o, TB_NOP); end
    checks++; if (stallreq_o !== 1'b0) begin errors++; $display("FAIL rb_stallreq_in_rst: got %b expected 0", stallreq_o); end
    step();
    rst = 1'b0; wb_ack_i = 1'b1; wb_dat_i = 32'hAAAA5555;
    @(negedge clk);
    checks++; if (wb_cyc_o !== 1'b0) begin errors++; $display("FAIL rb_cyc: got %b expected 0", wb_cyc_o); end
    checks++; if (cpu_data_o !== TB_NOP) begin errors++; $display("FAIL rb_late_ack: got %h expected %h", cpu_data_o, TB_NOP); end
    checks++; if (wb_adr_o !== 32'h0) begin errors++; $display("FAIL rb_adr: got %h expected 0", wb_adr_o); end
    step();
    wb_ack_i = 1'b0; wb_dat_i = 32'h0;
    @(negedge clk);
    checks++; if ({wb_cyc_o, stallreq_o} !== 2'b00) begin errors++; $display("FAIL rb_idle: got cyc=%b stallreq=%b expected 0 0", wb_cyc_o, stallreq_o); end
    step();
  endtask

  task automatic test_back_to_back();
    cpu_ce_i = 1'b1; cpu_addr_i = 32'h00000200;
    step();
    wb_ack_i = 1'b1; wb_dat_i = 32'h11111111; sb_q.push_back(32'h11111111);
    @(negedge clk);
    exp_data = sb_q.pop_front();
    checks++; if (cpu_data_o !== exp_data) begin errors++; $display("FAIL b2b_data0: got %h expected %h", cpu_data_o, exp_data); end
    checks++; if (wb_adr_o !== 32'h00000200) begin errors++; $display("FAIL b2b_adr0: got %h expected 00000200", wb_adr_o); end
    step();
    wb_ack_i = 1'b0; cpu_addr_i = 32'h00000204;
    @(negedge clk);
    checks++; if (stallreq_o !== 1'b1) begin errors++; $display("FAIL b2b_issue1: got %b expected 1", stallreq_o); end
    step();
    cpu_ce_i = 1'b0; wb_ack_i = 1'b1; wb_dat_i = 32'h22222222; sb_q.push_back(32'h22222222);
    @(negedge clk);
    exp_data = sb_q.pop_front();
    checks++; if (cpu_data_o !== exp_data) begin errors++; $display("FAIL b2b_data1: got %h expected %h", cpu_data_o, exp_data); end
    checks++; if (wb_adr_o !== 32'h00000204) begin errors++; $display("FAIL b2b_adr1: got %h expected 00000204", wb_adr_o); end
    step();
    wb_ack_i = 1'b0; wb_dat_i = 32'h0;
    @(negedge clk);
    checks++; if (wb_cyc_o !== 1'b0) begin errors++; $display("FAIL b2b_cyc_drop: got %b expected 0", wb_cyc_o); end
    step();
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_stall_hold();
    test_flush_vs_ack();
    test_timeout();
    test_reset_busy();
    test_back_to_back();
    checks++; if (sb_q.size() !== 0) begin errors++; $display("FAIL sb_leftover: got %0d entries expected 0", sb_q.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/inst_bus_if.md
INST_BUS_IF -- requirements
Module: inst_bus_if

Interface
- REQ-001 The block SHALL expose parameter NOP_INST, default 32'h00000000: the instruction returned when no valid fetch data exists.
- REQ-002 The block SHALL expose parameter TIMEOUT_CYCLES, default 16: the maximum number of BUSY cycles without wb_ack_i; legal range 2..255.
- REQ-003 The block SHALL have these ports:
  - clk  in  1  -- single clock; all registers on the rising edge.
  - rst  in  1  -- synchronous, active-high reset.
  - cpu_ce_i  in  1  -- fetch enable from pc_reg (rom_ce_o).
  - cpu_addr_i  in  32  -- fetch address (pc).
  - cpu_data_o  out  32  -- instruction to the core (rom_data_i).
  - stall_i  in  6  -- ctrl stall vector.
  - flush_i  in  1  -- abort the outstanding fetch.
  - stallreq_o  out  1  -- stall request to ctrl.
  - bus_err_o  out  1  -- one-cycle timeout pulse.
  - wb_adr_o  out  32  -- bus address.
  - wb_dat_i  in  32  -- bus read data.
  - wb_cyc_o  out  1  -- bus cycle.
  - wb_stb_o  out  1  -- bus strobe.
  - wb_we_o  out  1  -- write enable; constant 0.
  - wb_sel_o  out  4  -- byte lanes.
  - wb_ack_i  in  1  -- bus acknowledge.

Function
- REQ-004 The FSM SHALL have three states: IDLE, BUSY and WAIT_STALL.
- REQ-005 In IDLE with cpu_ce_i=1 and flush_i=0, at the next edge:
  - wb_adr_o SHALL take cpu_addr_i;
  - wb_cyc_o and wb_stb_o SHALL become 1;
  - wb_sel_o SHALL become 4'hF;
  - the timeout counter SHALL clear to 0;
  - the state SHALL become BUSY.
- REQ-006 In IDLE with cpu_ce_i=0 or flush_i=1, the block SHALL hold all bus outputs and remain in IDLE.
- REQ-007 In BUSY, wb_adr_o, wb_cyc_o, wb_stb_o and wb_sel_o SHALL stay constant until the cycle ends.
- REQ-008 In BUSY with wb_ack_i=1 and flush_i=0, at the next edge:
  - cyc, stb and sel SHALL clear;
  - rd_buf SHALL capture wb_dat_i;
  - the state SHALL become WAIT_STALL if stall_i!=0, otherwise IDLE.
- REQ-009 In BUSY with flush_i=1, at the next edge cyc, stb and sel SHALL clear, data SHALL be discarded and the state SHALL become IDLE; flush_i SHALL win over a simultaneous wb_ack_i.
- REQ-010 In BUSY without ack and without flush, the counter SHALL increment each cycle.
- REQ-011 When the counter equals TIMEOUT_CYCLES-1 without ack, that cycle SHALL act as an ack with data NOP_INST, and bus_err_o SHALL be 1 in the following cycle only.
- REQ-012 In WAIT_STALL, the block SHALL hold rd_buf and move to IDLE at the first edge where stall_i==0; flush_i in WAIT_STALL SHALL force IDLE.
- REQ-013 cpu_data_o SHALL be combinational:
  - wb_dat_i in BUSY with wb_ack_i=1 and flush_i=0;
  - NOP_INST on a timeout cycle;
  - rd_buf in WAIT_STALL;
  - NOP_INST otherwise.
- REQ-014 stallreq_o SHALL be combinational and equal to 1 when either:
  - IDLE and cpu_ce_i=1 and flush_i=0; or
  - BUSY and wb_ack_i=0 and flush_i=0 and not a timeout cycle.
  It SHALL be 0 otherwise.
- REQ-015 A wb_ack_i arriving in IDLE or WAIT_STALL SHALL be ignored.
- REQ-016 Minimum fetch latency SHALL be 2 cycles: one IDLE issue cycle, then a BUSY cycle with ack; stallreq_o SHALL be 1 in the issue cycle.
- REQ-017 wb_we_o SHALL be tied to 0.

Reset
- REQ-018 With rst=1 at an edge, the following SHALL apply:
  - state SHALL be IDLE;
  - wb_adr_o SHALL be 0;
  - wb_cyc_o, wb_stb_o and wb_sel_o SHALL be 0;
  - rd_buf SHALL be NOP_INST;
  - the counter SHALL be 0;
  - bus_err_o SHALL be 0.
- REQ-019 Reset during BUSY SHALL drop wb_cyc_o and wb_stb_o at that edge; a late ack SHALL be ignored.
- REQ-020 While rst=1, cpu_data_o SHALL be NOP_INST and stallreq_o SHALL be 0.

Verification
- REQ-021 Zero-wait fetch: ce=1, addr=0x00000004, ack in the first BUSY cycle with data 0x34011100 -> cyc high for 1 cycle, cpu_data_o=0x34011100 in that cycle, stallreq_o 1 then 0.
- REQ-022 Wait states: ack after 3 BUSY cycles, data 0x00221825 -> stallreq_o=1 for 4 cycles (issue + 3), wb_adr_o stable throughout.
- REQ-023 Stall hold: ack with data 0x3C020404 while stall_i=6'b000111 for 2 more cycles -> WAIT_STALL, cpu_data_o=0x3C020404 for 2 cycles, then IDLE.
- REQ-024 Flush vs ack: flush_i=1 and ack=1 in the same BUSY cycle -> cpu_data_o=NOP_INST, stallreq_o=0, next state IDLE, no data captured.
- REQ-025 Timeout: TIMEOUT_CYCLES=4, no ack -> cyc drops after 4 BUSY cycles, cpu_data_o=0x00000000, bus_err_o pulses 1 cycle.
- REQ-026 Reset mid-BUSY: rst=1 in BUSY, ack 1 cycle later -> cyc=0 after the edge, state IDLE, late ack ignored.
